// File: rtl/ps2_dec_pkg.sv
// ps2_dec_pkg -- shared definitions for the PS/2 scancode decoder.
//   state_e : decoder FSM state encoding (IDLE, POP, WAIT, FLUSH)
//   SC_EXT  : set-2 extended-key prefix byte
//   SC_BRK  : set-2 break (key release) prefix byte
package ps2_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a byte in the receiver FIFO
    POP   = 2'd1,  // pop strobe issued, byte consumed
    WAIT  = 2'd2,  // let the FIFO head settle before the next look
    FLUSH = 2'd3   // receiver overflowed, clearing it
  } state_e;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

endpackage

// File: rtl/scancode_ascii_rom.sv
// scancode_ascii_rom -- combinational set-2 scancode to ASCII lookup.
// Covers lowercase letters, digits, space and enter; anything else maps to 0.
// Ports:
//   code_i  [7:0] set-2 make code
//   ascii_o [7:0] ASCII character, 8'h00 when unmapped
module scancode_ascii_rom (
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives ascii_o (no latch).
    ascii_o = 8'h00;
    unique case (code_i)
      8'h1C: ascii_o = 8'h61; 8'h32: ascii_o = 8'h62; 8'h21: ascii_o = 8'h63;
      8'h23: ascii_o = 8'h64; 8'h24: ascii_o = 8'h65; 8'h2B: ascii_o = 8'h66;
      8'h34: ascii_o = 8'h67; 8'h33: ascii_o = 8'h68; 8'h43: ascii_o = 8'h69;
      8'h3B: ascii_o = 8'h6A; 8'h42: ascii_o = 8'h6B; 8'h4B: ascii_o = 8'h6C;
      8'h3A: ascii_o = 8'h6D; 8'h31: ascii_o = 8'h6E; 8'h44: ascii_o = 8'h6F;
      8'h4D: ascii_o = 8'h70; 8'h15: ascii_o = 8'h71; 8'h2D: ascii_o = 8'h72;
      8'h1B: ascii_o = 8'h73; 8'h2C: ascii_o = 8'h74; 8'h3C: ascii_o = 8'h75;
      8'h2A: ascii_o = 8'h76; 8'h1D: ascii_o = 8'h77; 8'h22: ascii_o = 8'h78;
      8'h35: ascii_o = 8'h79; 8'h1A: ascii_o = 8'h7A;
      8'h45: ascii_o = 8'h30; 8'h16: ascii_o = 8'h31; 8'h1E: ascii_o = 8'h32;
      8'h26: ascii_o = 8'h33; 8'h25: ascii_o = 8'h34; 8'h2E: ascii_o = 8'h35;
      8'h36: ascii_o = 8'h36; 8'h3D: ascii_o = 8'h37; 8'h3E: ascii_o = 8'h38;
      8'h46: ascii_o = 8'h39;
      8'h29: ascii_o = 8'h20;  // space
      8'h5A: ascii_o = 8'h0D;  // enter
      default: ascii_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder -- pops set-2 bytes from a PS/2 receiver FIFO and turns
// E0/F0-prefixed sequences into one-cycle key events with held-key tracking.
// Build option: define PS2_DEC_ASCII_EN to drive key_ascii from
// scancode_ascii_rom; otherwise key_ascii is constant 0.
// Ports:
//   clk, clrn            clock, async active-low reset
//   ps2_data/ready       FIFO head byte and non-empty flag
//   ps2_overflow         FIFO overflowed -> flush
//   ps2_nextdata_n       active-low pop strobe (one cycle per byte)
//   kbd_clrn             active-low receiver clear (during FLUSH)
//   key_valid            one-cycle event strobe
//   key_code/ascii/ext/release/repeat  event attributes, held between events
//   press_count [CNT_W]  new presses (wraps, repeats and breaks excluded)
module ps2_scancode_decoder
  import ps2_dec_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             ps2_nextdata_n,
  output logic             kbd_clrn,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic             key_ext,
  output logic             key_release,
  output logic             key_repeat,
  output logic [CNT_W-1:0] press_count
);

  state_e           state_q, state_d;
  logic             ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic             held_vld_q, held_vld_d, held_ext_q, held_ext_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             nextdata_n_q, nextdata_n_d, kbd_clrn_q, kbd_clrn_d;
  logic             valid_q, valid_d, ext_q, ext_d, rel_q, rel_d, rep_q, rep_d;
  logic [7:0]       code_q, code_d, ascii_q, ascii_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       lut_ascii;
  logic             held_match;

`ifdef PS2_DEC_ASCII_EN
  scancode_ascii_rom u_rom (
    .code_i  (ps2_data),
    .ascii_o (lut_ascii)
  );
`else
  assign lut_ascii = 8'h00;
`endif

  // Current byte, with the pending E0 state, names the key that is held.
  assign held_match = held_vld_q && (held_ext_q == ext_pend_q) &&
                      (held_code_q == ps2_data);

  always_comb begin
    state_d      = state_q;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    held_vld_d   = held_vld_q;
    held_ext_d   = held_ext_q;
    held_code_d  = held_code_q;
    nextdata_n_d = 1'b1;
    kbd_clrn_d   = 1'b1;
    valid_d      = 1'b0;
    code_d       = code_q;
    ascii_d      = ascii_q;
    ext_d        = ext_q;
    rel_d        = rel_q;
    rep_d        = rep_q;
    count_d      = count_q;

    // Overflow wins over everything, including a ready byte this cycle.
    if (ps2_overflow) begin
      state_d    = FLUSH;
      kbd_clrn_d = 1'b0;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
      held_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (ps2_ready) begin
          state_d      = POP;
          nextdata_n_d = 1'b0;
          if (ps2_data == SC_EXT) begin
            ext_pend_d = 1'b1;
          end else if (ps2_data == SC_BRK) begin
            brk_pend_d = 1'b1;
          end else begin
            valid_d    = 1'b1;
            code_d     = ps2_data;
            ascii_d    = ext_pend_q ? 8'h00 : lut_ascii;
            ext_d      = ext_pend_q;
            rel_d      = brk_pend_q;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
            if (brk_pend_q) begin
              rep_d = 1'b0;
              if (held_match) held_vld_d = 1'b0;
            end else if (held_match) begin
              rep_d = 1'b1;  // typematic repeat: not a new press
            end else begin
              rep_d       = 1'b0;
              count_d     = count_q + CNT_W'(1);
              held_vld_d  = 1'b1;
              held_ext_d  = ext_pend_q;
              held_code_d = ps2_data;
            end
          end
        end
        POP:     state_d = WAIT;
        WAIT:    state_d = IDLE;
        FLUSH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      held_vld_q   <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
      nextdata_n_q <= 1'b1;
      kbd_clrn_q   <= 1'b1;
      valid_q      <= 1'b0;
      code_q       <= 8'h00;
      ascii_q      <= 8'h00;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      rep_q        <= 1'b0;
      count_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      held_vld_q   <= held_vld_d;
      held_ext_q   <= held_ext_d;
      held_code_q  <= held_code_d;
      nextdata_n_q <= nextdata_n_d;
      kbd_clrn_q   <= kbd_clrn_d;
      valid_q      <= valid_d;
      code_q       <= code_d;
      ascii_q      <= ascii_d;
      ext_q        <= ext_d;
      rel_q        <= rel_d;
      rep_q        <= rep_d;
      count_q      <= count_d;
    end
  end

  assign ps2_nextdata_n = nextdata_n_q;
  assign kbd_clrn       = kbd_clrn_q;
  assign key_valid      = valid_q;
  assign key_code       = code_q;
  assign key_ascii      = ascii_q;
  assign key_ext        = ext_q;
  assign key_release    = rel_q;
  assign key_repeat     = rep_q;
  assign press_count    = count_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder -- directed self-checking bench for ps2_scancode_decoder.
module tb_ps2_scancode_decoder;

`ifdef PS2_DEC_ASCII_EN
  localparam logic [7:0] EXP_ASCII_A = 8'h61;
`else
  localparam logic [7:0] EXP_ASCII_A = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       ps2_overflow = 1'b0;
  logic       ps2_nextdata_n, kbd_clrn, key_valid, key_ext, key_release, key_repeat;
  logic [7:0] key_code, key_ascii, press_count;

  int tests = 0;
  int fails = 0;
  int pop_cnt = 0;
  int kv_cnt = 0;
  int flush_cnt = 0;
  int p0, k0, f0;

  ps2_scancode_decoder #(.CNT_W(8)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .ps2_data       (ps2_data),
    .ps2_ready      (ps2_ready),
    .ps2_overflow   (ps2_overflow),
    .ps2_nextdata_n (ps2_nextdata_n),
    .kbd_clrn       (kbd_clrn),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_ascii      (key_ascii),
    .key_ext        (key_ext),
    .key_release    (key_release),
    .key_repeat     (key_repeat),
    .press_count    (press_count)
  );

  always #5 clk = ~clk;

  // Cycle counters for the active-low strobes and the event strobe.
  always @(negedge clk) begin
    if (!ps2_nextdata_n) pop_cnt++;
    if (!kbd_clrn)       flush_cnt++;
    if (key_valid)       kv_cnt++;
  end

  task automatic snap();
    p0 = pop_cnt; k0 = kv_cnt; f0 = flush_cnt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0; ps2_ready = 1'b0; ps2_overflow = 1'b0; ps2_data = 8'h00;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  // Present one byte as FIFO head until popped, then return once FSM is idle.
  task automatic send_byte(input logic [7:0] b);
    bit seen = 0;
    @(negedge clk);
    ps2_data = b; ps2_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!ps2_nextdata_n) begin seen = 1; break; end
    end
    ps2_ready = 1'b0;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL pop_timeout byte=%h: no pop strobe within 10 cycles", b);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    tests++;
    if ({ps2_nextdata_n, kbd_clrn, key_valid, key_code, key_ascii, key_ext,
         key_release, key_repeat, press_count} !== {1'b1, 1'b1, 1'b0, 8'h00,
         8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL %s: got nd=%b clr=%b kv=%b code=%h asc=%h ext=%b rel=%b rep=%b cnt=%h, expected 1 1 0 00 00 0 0 0 00",
               tag, ps2_nextdata_n, kbd_clrn, key_valid, key_code, key_ascii,
               key_ext, key_release, key_repeat, press_count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_values("reset_state");
  endtask

  task automatic test_single_make();
    do_reset(); snap();
    send_byte(8'h1C);
    tests++;
    if (pop_cnt - p0 !== 1 || kv_cnt - k0 !== 1) begin
      fails++;
      $display("FAIL make_strobes: pops=%0d events=%0d, expected 1 1", pop_cnt - p0, kv_cnt - k0);
    end
    tests++;
    if ({key_code, key_ascii, key_ext, key_release, key_repeat, press_count} !==
        {8'h1C, EXP_ASCII_A, 1'b0, 1'b0, 1'b0, 8'h01}) begin
      fails++;
      $display("FAIL make_fields: code=%h asc=%h ext=%b rel=%b rep=%b cnt=%h, expected 1c %h 0 0 0 01",
               key_code, key_ascii, key_ext, key_release, key_repeat, press_count, EXP_ASCII_A);
    end
  endtask

  task automatic test_break();
    do_reset(); snap();
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    tests++;
    if (kv_cnt - k0 !== 2 || key_release !== 1'b1 || key_code !== 8'h1C || press_count !== 8'h01) begin
      fails++;
      $display("FAIL break: events=%0d rel=%b code=%h cnt=%h, expected 2 1 1c 01",
               kv_cnt - k0, key_release, key_code, press_count);
    end
    // Held key cleared by the break: pressing again is a new press.
    send_byte(8'h1C);
    tests++;
    if (key_repeat !== 1'b0 || key_release !== 1'b0 || press_count !== 8'h02) begin
      fails++;
      $display("FAIL break_held_cleared: rep=%b rel=%b cnt=%h, expected 0 0 02",
               key_repeat, key_release, press_count);
    end
  endtask

  task automatic test_extended();
    do_reset(); snap();
    send_byte(8'hE0);
    tests++;
    if (kv_cnt - k0 !== 0) begin
      fails++;
      $display("FAIL ext_prefix_no_event: events=%0d, expected 0", kv_cnt - k0);
    end
    send_byte(8'h75);
    tests++;
    if (kv_cnt - k0 !== 1 || key_code !== 8'h75 || key_ext !== 1'b1 ||
        key_ascii !== 8'h00 || press_count !== 8'h01) begin
      fails++;
      $display("FAIL extended: events=%0d code=%h ext=%b asc=%h cnt=%h, expected 1 75 1 00 01",
               kv_cnt - k0, key_code, key_ext, key_ascii, press_count);
    end
  endtask

  task automatic test_repeat();
    do_reset();
    send_byte(8'h1C); send_byte(8'h1C);
    tests++;
    if (key_repeat !== 1'b1 || press_count !== 8'h01) begin
      fails++;
      $display("FAIL repeat_2: rep=%b cnt=%h, expected 1 01", key_repeat, press_count);
    end
    send_byte(8'h1C);
    tests++;
    if (key_repeat !== 1'b1 || press_count !== 8'h01) begin
      fails++;
      $display("FAIL repeat_3: rep=%b cnt=%h, expected 1 01", key_repeat, press_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'hE0); snap();
    @(negedge clk); ps2_overflow = 1'b1;
    @(negedge clk); ps2_overflow = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (flush_cnt - f0 !== 1 || kv_cnt - k0 !== 0) begin
      fails++;
      $display("FAIL overflow_flush: clr_low_cycles=%0d events=%0d, expected 1 0", flush_cnt - f0, kv_cnt - k0);
    end
    send_byte(8'h75);
    tests++;
    if (key_ext !== 1'b0 || key_code !== 8'h75 || press_count !== 8'h01) begin
      fails++;
      $display("FAIL overflow_prefix_dropped: ext=%b code=%h cnt=%h, expected 0 75 01",
               key_ext, key_code, press_count);
    end
    // Overflow and ready together: flush only, byte not popped.
    snap();
    @(negedge clk); ps2_data = 8'h1C; ps2_ready = 1'b1; ps2_overflow = 1'b1;
    @(negedge clk); ps2_ready = 1'b0; ps2_overflow = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (pop_cnt - p0 !== 0 || flush_cnt - f0 !== 1 || kv_cnt - k0 !== 0 || press_count !== 8'h01) begin
      fails++;
      $display("FAIL overflow_priority: pops=%0d clr_low=%0d events=%0d cnt=%h, expected 0 1 0 01",
               pop_cnt - p0, flush_cnt - f0, kv_cnt - k0, press_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); snap();
    @(negedge clk); ps2_data = 8'h1C; ps2_ready = 1'b1;
    repeat (12) @(negedge clk);
    ps2_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (pop_cnt - p0 !== 4 || kv_cnt - k0 !== 4 || press_count !== 8'h01 || key_repeat !== 1'b1) begin
      fails++;
      $display("FAIL back_to_back: pops=%0d events=%0d cnt=%h rep=%b, expected 4 4 01 1",
               pop_cnt - p0, kv_cnt - k0, press_count, key_repeat);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) send_byte(i[0] ? 8'h32 : 8'h1C);
    tests++;
    if (press_count !== 8'hFF) begin
      fails++;
      $display("FAIL wrap_pre: cnt=%h, expected ff", press_count);
    end
    send_byte(8'h1B);
    tests++;
    if (press_count !== 8'h00 || key_code !== 8'h1B) begin
      fails++;
      $display("FAIL wrap: cnt=%h code=%h, expected 00 1b", press_count, key_code);
    end
    send_byte(8'hF0); send_byte(8'h1B);
    tests++;
    if (press_count !== 8'h00 || key_release !== 1'b1) begin
      fails++;
      $display("FAIL break_no_count: cnt=%h rel=%b, expected 00 1", press_count, key_release);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h1C); send_byte(8'hF0);
    @(negedge clk); #2 clrn = 1'b0;
    #1 check_reset_values("async_reset_mid");
    @(negedge clk); clrn = 1'b1;
    send_byte(8'h1C);
    tests++;
    if (key_release !== 1'b0 || key_repeat !== 1'b0 || press_count !== 8'h01) begin
      fails++;
      $display("FAIL reset_drops_prefix: rel=%b rep=%b cnt=%h, expected 0 0 01",
               key_release, key_repeat, press_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_break();
    test_extended();
    test_repeat();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
